xbar_cfg_chain: RTL
===================

// Module: xbar_cfg_chain
// PURPOSE
//  Parametrised successor of the LUT-tile input crossbar. Each of OUT_W outputs selects one of IN_W inputs.
//  The select field is SEL_W bits per output.
//  Selects are no longer a static wide port. They are loaded serially through a scan chain into a shadow
//  register, then committed atomically into an active register, so routing never glitches mid-load.
//  An optional output pipeline stage is provided. Sits between the tile input pins and the LUT/FF inputs.
// PARAMETERS
//  IN_W   23  number of crossbar inputs
//  OUT_W  30  number of crossbar outputs
//  SEL_W   5  select bits per output; must satisfy 2**SEL_W >= IN_W
//  PIPE    1  0 = combinational data path, 1 = registered outputs
//  (derived) CFG_W = OUT_W*SEL_W = 150; CNT_W = $clog2(CFG_W+1)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  io_xbar_in     in   IN_W    crossbar data inputs
//  io_xbar_out    out  OUT_W   crossbar data outputs
//  io_cfg_en      in   1       shift enable for the scan chain
//  io_cfg_din     in   1       serial config bit in
//  io_cfg_dout    out  1       serial config bit out (shadow[0]); used to chain tiles
//  io_cfg_commit  in   1       single-cycle request: copy shadow -> active
//  io_cfg_full    out  1       high when CFG_W bits have been shifted since the last reset/commit
//  io_cfg_err     out  1       one-cycle pulse: commit requested while io_cfg_full=0
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - shadow, active, bit counter and output regs are all cleared to 0.
//   - io_cfg_dout, io_cfg_full and io_cfg_err are 0.
//   - With active=0, every output selects io_xbar_in[0].
//  Shadow register (CFG_W bits):
//   - On io_cfg_en=1: shadow <= {io_cfg_din, shadow[CFG_W-1:1]}.
//   - The first bit shifted lands at bit 0 after exactly CFG_W shifts.
//   - io_cfg_dout = shadow[0], registered, i.e. its value before the shift.
//  Bit counter:
//   - Increments on each shift.
//   - Saturates at CFG_W; further shifts keep shifting data, but the count stays at CFG_W.
//   - io_cfg_full = (count == CFG_W).
//  FSM, states LOAD and READY (READY <=> io_cfg_full):
//   - LOAD -> READY when the count reaches CFG_W.
//   - READY + commit -> LOAD: active <= shadow (pre-shift value that cycle); count <= io_cfg_en ? 1 : 0.
//     Shadow is not cleared.
//   - LOAD + commit: active is unchanged; io_cfg_err pulses high the next cycle for 1 cycle; count unchanged.
//   - Simultaneous shift + commit in READY: commit uses the old shadow; the shift still occurs; count = 1.
//  Select decode:
//   - sel_k = active[k*SEL_W +: SEL_W].
//   - out_k = (sel_k < IN_W) ? io_xbar_in[sel_k] : 1'b0. Out-of-range selects drive 0, never X.
//  Latency:
//   - PIPE=0: output follows io_xbar_in combinationally.
//   - PIPE=1: io_xbar_out is registered; it reflects inputs sampled at the previous edge.
//   - New routing is visible the cycle after the commit edge (PIPE=0), or one cycle later (PIPE=1).
//  Reset mid-load: the partial shadow is discarded, the count is 0, and active returns to 0.
// TESTING
//  1 Reset; drive io_xbar_in=23'h000001 -> all 30 outputs = 1 (PIPE=1: from 2nd cycle); full=0.
//  2 Shift 150 bits so that sel_k = k mod 23; commit; drive in=23'h2AAAAA -> out_k = in[k mod 23];
//    full goes 1 after 150th shift and 0 after commit.
//  3 Commit after only 149 shifts -> io_cfg_err pulses 1 cycle; outputs keep old routing; full stays 0.
//  4 Load sel_0=31, sel_1=23, rest 0; in=all 1s -> out[0]=0, out[1]=0, out[29:2]=all 1s.
//  5 Shift 150 bits, then shift+commit same cycle -> active = pre-shift shadow; count=1;
//    io_cfg_dout shows bit 0 of shadow each shift.
//  6 Assert reset after 75 shifts -> count 0, full 0; next 150-bit load + commit routes correctly.

Source files
------------

// File: rtl/xbar_cfg_chain.sv
// ---------------------------------------------------------------------------
// xbar_cfg_chain
//
// Purpose:
//   Input crossbar for a LUT tile. Each of OUT_W outputs picks one of IN_W
//   inputs using a SEL_W-bit select field. The selects are not a wide static
//   port: they are shifted in serially through a scan chain into a shadow
//   register and then committed in one cycle into the active register, so the
//   routing never changes while a new configuration is being loaded.
//   An optional register stage on the data outputs is selected with PIPE.
//   SEL_W must be wide enough to address every input (2**SEL_W >= IN_W).
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   io_xbar_in     [IN_W]  crossbar data inputs
//   io_xbar_out    [OUT_W] crossbar data outputs
//   io_cfg_en      shift enable for the scan chain
//   io_cfg_din     serial configuration bit in
//   io_cfg_dout    serial configuration bit out (shadow bit 0), for chaining
//   io_cfg_commit  single-cycle request to copy shadow into active
//   io_cfg_full    high once a complete configuration has been shifted in
//   io_cfg_err     one-cycle pulse after a commit requested while not full
// ---------------------------------------------------------------------------
module xbar_cfg_chain #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 30,
  parameter int SEL_W = 5,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  io_xbar_in,
  output logic [OUT_W-1:0] io_xbar_out,
  input  logic             io_cfg_en,
  input  logic             io_cfg_din,
  output logic             io_cfg_dout,
  input  logic             io_cfg_commit,
  output logic             io_cfg_full,
  output logic             io_cfg_err
);

  localparam int CFG_W = OUT_W * SEL_W;
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam int PAD_W = 2 ** SEL_W;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] r_active;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic [0:0]       r_state;
  logic             r_err;
  logic             w_commitOk;
  logic [PAD_W-1:0] w_inPad;
  logic [OUT_W-1:0] w_route;

  // A commit only takes effect once a whole configuration is in the shadow.
  assign w_commitOk = io_cfg_commit && (r_state == ST_READY);

  // Bit counter: a successful commit restarts the count (counting a shift
  // that happens in the same cycle); otherwise each shift counts up until
  // the counter saturates at a full configuration.
  always_comb begin
    w_countNext = r_count;
    if (w_commitOk) begin
      w_countNext = io_cfg_en ? CNT_W'(1) : '0;
    end else if (io_cfg_en && (r_count != CNT_MAX)) begin
      w_countNext = r_count + CNT_W'(1);
    end
  end

  // Scan chain, active register, counter and LOAD/READY state.
  // The active register copies the shadow value from before this cycle's
  // shift, so a shift and a commit in the same cycle commit the old data.
  // The state follows the next count, which keeps READY equivalent to a
  // full count in every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_state  <= ST_LOAD;
      r_err    <= 1'b0;
    end else begin
      if (io_cfg_en) begin
        r_shadow <= {io_cfg_din, r_shadow[CFG_W-1:1]};
      end
      if (w_commitOk) begin
        r_active <= r_shadow;
      end
      r_count <= w_countNext;
      r_state <= (w_countNext == CNT_MAX) ? ST_READY : ST_LOAD;
      r_err   <= io_cfg_commit && (r_state == ST_LOAD);
    end
  end

  // Zero-extend the inputs to the full select range so that select values
  // beyond the last real input read a constant 0 rather than an undefined bit.
  always_comb begin
    w_inPad             = '0;
    w_inPad[IN_W-1:0]   = io_xbar_in;
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_sel
    assign w_route[k] = w_inPad[r_active[k*SEL_W +: SEL_W]];
  end

  // Optional output register; when present it is cleared by reset along
  // with the configuration state.
  if (PIPE != 0) begin : g_pipe
    logic [OUT_W-1:0] r_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else begin
        r_out <= w_route;
      end
    end

    assign io_xbar_out = r_out;
  end else begin : g_comb
    assign io_xbar_out = w_route;
  end

  assign io_cfg_dout = r_shadow[0];
  assign io_cfg_full = (r_state == ST_READY);
  assign io_cfg_err  = r_err;

endmodule
